instruction_cache: RTL
======================

# instruction_cache

Direct-mapped, read-only instruction cache between the single-cycle MIPS core's instruction port (`instruction_memory_a` / `instruction_memory_rd`) and a slower word-wide backing instruction memory with a ready handshake. Hits return the instruction combinationally in the same cycle, so the core keeps single-cycle behaviour. A miss raises `cpu_stall`, which the top level uses to hold the PC register and suppress register-file and data-memory writes. The stall lasts while the cache refills a 4-word line from backing memory.

## Interface
- `LINES`, 16: number of cache lines; must be a power of two, minimum 2. `IDX = log2(LINES)`.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_addr` in 32: fetch byte address (the core's `pc`). Bits [1:0] are ignored.
- `cpu_rdata` out 32: instruction word for `cpu_addr`; valid only when `cpu_stall`=0.
- `cpu_stall` out 1: 1 = instruction not available; the core must hold `cpu_addr` and commit nothing.
- `flush` in 1: 1-cycle pulse; invalidate all lines.
- `mem_req` out 1: backing-memory read request.
- `mem_addr` out 32: word-aligned backing-memory address; bits [1:0] = 0.
- `mem_ready` in 1: backing memory accepts the request and presents `mem_rdata` in the same cycle.
- `mem_rdata` in 32: backing-memory read data.

## Operation
- **Address split:** word = [3:2]; index = [3+IDX:4]; tag = [31:4+IDX].
- **Storage:** `LINES`×4×32 data array, `LINES` tags, `LINES` valid bits.
- **FSM states:** IDLE, REFILL.
- **IDLE, flush=1:**
  - All valid bits clear at the edge.
  - cpu_stall=1 and cpu_rdata=0 for that cycle; no miss starts.
  - Stay in IDLE.
- **IDLE, hit** (valid[index] and tag match):
  - cpu_stall=0; cpu_rdata = data[index][word].
- **IDLE, miss:**
  - cpu_stall=1 and cpu_rdata=0 combinationally.
  - At the edge: latch `cpu_addr[31:4]` into miss_line; clear valid[index]; beat=0; go to REFILL.
- **REFILL:**
  - cpu_stall=1 and cpu_rdata=0.
  - mem_req=1; mem_addr = {miss_line, beat, 2'b00}.
  - On mem_ready=1: write mem_rdata into data[miss_index][beat]; beat++.
  - On acceptance of beat 3: write the tag, set valid (unless flush is pending), go to IDLE.
  - mem_ready=0: hold mem_addr and beat unchanged.
- **flush during REFILL:** recorded as flush_pending; the refill still completes all 4 beats. On completion, all valid bits clear, including the refilled line, and flush_pending clears.
- **cpu_addr changes during REFILL:** ignored; the refill uses miss_line. IDLE then evaluates whatever `cpu_addr` is current.
- **Beat counter:** 2 bits; it wraps 3→0 only on refill completion.
- **Reset:**
  - State = IDLE; all valid = 0; beat = 0; flush_pending = 0.
  - While reset=1: cpu_stall=0, cpu_rdata=0, mem_req=0, mem_addr=0 (forced).
  - Reset during REFILL abandons the refill; the partial line stays invalid. Backing memory must tolerate a dropped request.

## Timing
- Hit: 0-cycle latency, combinational from `cpu_addr`.
- Miss detected in cycle M (stall=1). mem_req rises in M+1.
- Zero-wait memory (mem_ready=1 constantly): beats accepted in M+1..M+4; IDLE in M+5; hit with stall=0 in M+5. Miss penalty = 5 cycles.
- Each mem_ready=0 cycle during REFILL adds 1 cycle.
- mem_req is driven only from the state register, never combinationally from `cpu_addr`.
- Tag, valid and data writes take effect at the edge; the first read of new contents is the following cycle.

## Test plan
- **Reset, then miss:** Reset, then cpu_addr=0x0000_0000 with mem_ready=1 and mem_rdata = 0xA0+beat.
  - mem_addr sequence is 0x0, 0x4, 0x8, 0xC in cycles 1–4.
  - stall drops in cycle 5 with cpu_rdata=0xA0.
- **Same-line hits:** After the above, cpu_addr=0x4, 0x8, 0xC.
  - stall=0; cpu_rdata=0xA1, 0xA2, 0xA3; mem_req=0 throughout.
- **Conflict:** With LINES=16, cpu_addr=0x100 (same index 0, tag 1).
  - A miss refills addresses 0x100–0x10C.
  - Afterwards, cpu_addr=0x0 misses again.
- **Wait states:** mem_ready alternating 0/1 during a refill.
  - mem_addr holds during ready=0 cycles.
  - Total stall = 9 cycles; data is correct.
- **Flush mid-refill:** flush pulsed during beat 1 of a refill at 0x20.
  - All 4 beats still complete.
  - The next lookup of 0x20 misses, and a prior resident line (0x0) also misses.
- **Reset mid-refill:** reset asserted after beat 2.
  - Next cycle: mem_req=0 and stall=0 while reset is high.
  - After release, 0x20 misses and performs a full 4-beat refill.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped read-only I-cache with 4-word lines: hits are combinational (0 cycles); a miss stalls the core
// and refills one word per mem_ready beat. Refill waits on mem_ready, and cpu_stall holds the core until the line is installed.
module instruction_cache #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 28 - IDX;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAGW-1:0]   tag_q  [LINES];
  logic [TAGW-1:0]   tag_d  [LINES];
  logic [31:0]       data_q [LINES*4];
  logic [31:0]       data_d [LINES*4];
  logic [27:0]       miss_line_q, miss_line_d;
  logic [1:0]        beat_q, beat_d;
  logic              flush_pending_q, flush_pending_d;

  logic [IDX-1:0]    cpu_index;
  logic [TAGW-1:0]   cpu_tag;
  logic [1:0]        cpu_word;
  logic [IDX-1:0]    miss_index;
  logic              hit;
  logic              unused_addr_bits;

  assign cpu_index        = cpu_addr[3+IDX:4];
  assign cpu_tag          = cpu_addr[31:4+IDX];
  assign cpu_word         = cpu_addr[3:2];
  assign miss_index       = miss_line_q[IDX-1:0];
  assign hit              = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    tag_d           = tag_q;
    data_d          = data_q;
    miss_line_d     = miss_line_q;
    beat_d          = beat_q;
    flush_pending_d = flush_pending_q;
    cpu_stall       = 1'b0;
    cpu_rdata       = 32'd0;
    mem_req         = 1'b0;
    mem_addr        = 32'd0;

    // Reset forces all outputs low and blocks array writes; state is cleared in the flop block.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            cpu_stall = 1'b1;
            valid_d   = '0;
          end else if (hit) begin
            cpu_rdata = data_q[{cpu_index, cpu_word}];
          end else begin
            cpu_stall           = 1'b1;
            miss_line_d         = cpu_addr[31:4];
            valid_d[cpu_index]  = 1'b0;
            beat_d              = 2'd0;
            state_d             = REFILL;
          end
        end
        REFILL: begin
          cpu_stall = 1'b1;
          mem_req   = 1'b1;
          mem_addr  = {miss_line_q, beat_q, 2'b00};
          if (flush) begin
            flush_pending_d = 1'b1;
          end
          if (mem_ready) begin
            data_d[{miss_index, beat_q}] = mem_rdata;
            beat_d                       = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              tag_d[miss_index] = miss_line_q[27:IDX];
              // A flush seen at any point of the refill, including this last beat, wins over the install.
              if (flush_pending_q || flush) begin
                valid_d = '0;
              end else begin
                valid_d[miss_index] = 1'b1;
              end
              flush_pending_d = 1'b0;
              state_d         = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      miss_line_q     <= 28'd0;
      beat_q          <= 2'd0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      miss_line_q     <= miss_line_d;
      beat_q          <= beat_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule
